binary16_div: RTL and testbench

BINARY16_DIV -- requirements
Module: binary16_div

---
 rtl/binary16_div.sv | 137 +++++++++++++
 tb/tb_binary16_div.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/binary16_div.sv
// binary16 divider: 12-step restoring mantissa division, one normalize cycle, then a registered result.
// Latency is fixed at 14 edges for every operand pair; special cases are resolved at accept time.
//
// state  | meaning
// IDLE   | waiting for a request, ready high
// DIVIDE | one restoring quotient bit per cycle, counter 11 down to 0
// NORM   | normalize quotient, range-check exponent, register result
// DONE   | result valid pulse, ready high (back-to-back accept allowed)
module binary16_div (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        data_valid_in,
  output logic        ready,
  output logic [15:0] result,
  output logic        data_valid_out
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t state, state_nxt;

  logic        sign_q;
  logic [4:0]  exp_a, exp_b;
  logic [12:0] rem;
  logic [10:0] dvsr;
  logic [11:0] quo;
  logic [3:0]  cnt;
  logic        spec_q;
  logic [15:0] spec_val;

  logic        accept;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
  logic        spec_hit;
  logic [15:0] spec_res;
  logic        rem_ge;
  logic [12:0] rem_sub;
  logic signed [6:0] e_norm;
  logic [9:0]  mant_norm;
  logic [15:0] norm_res;

  assign ready  = (state == IDLE) || (state == DONE);
  assign accept = data_valid_in && ready;

  assign a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
  assign b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
  assign a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
  assign b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
  assign a_zero = (a[14:10] == 5'h00);
  assign b_zero = (b[14:10] == 5'h00);
  assign sgn    = a[15] ^ b[15];

  // Subnormal operands count as zero here, so 0/subnormal is also NaN.
  always_comb begin
    spec_hit = 1'b1;
    spec_res = 16'h0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_res = 16'h7E00;
    else if (a_zero || b_inf)
      spec_res = {sgn, 15'h0};
    else if (b_zero || a_inf)
      spec_res = {sgn, 5'h1F, 10'h0};
    else
      spec_hit = 1'b0;
  end

  assign rem_ge  = rem >= {2'b00, dvsr};
  assign rem_sub = rem_ge ? (rem - {2'b00, dvsr}) : rem;

  assign e_norm    = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b})
                   + (quo[11] ? 7'sd15 : 7'sd14);
  assign mant_norm = quo[11] ? quo[10:1] : quo[9:0];

  always_comb begin
    norm_res = {sign_q, e_norm[4:0], mant_norm};
    if (spec_q)
      norm_res = spec_val;
    else if (e_norm >= 7'sd31)
      norm_res = {sign_q, 5'h1F, 10'h0};
    else if (e_norm <= 7'sd0)
      norm_res = {sign_q, 15'h0};
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? DIVIDE : IDLE;
      DIVIDE:  state_nxt = (cnt == 4'd0) ? NORM : DIVIDE;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = accept ? DIVIDE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sign_q         <= 1'b0;
      exp_a          <= 5'h0;
      exp_b          <= 5'h0;
      rem            <= 13'h0;
      dvsr           <= 11'h0;
      quo            <= 12'h0;
      cnt            <= 4'h0;
      spec_q         <= 1'b0;
      spec_val       <= 16'h0;
      result         <= 16'h0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      if (accept) begin
        sign_q   <= sgn;
        exp_a    <= a[14:10];
        exp_b    <= b[14:10];
        rem      <= {2'b01, a[9:0]};
        dvsr     <= {1'b1, b[9:0]};
        quo      <= 12'h0;
        cnt      <= 4'd11;
        spec_q   <= spec_hit;
        spec_val <= spec_res;
      end else if (state == DIVIDE) begin
        quo <= {quo[10:0], rem_ge};
        rem <= {rem_sub[11:0], 1'b0};
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end else if (state == NORM) begin
        result         <= norm_res;
        data_valid_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_binary16_div.sv
// Self-checking bench for binary16_div: directed vector table, randomized ops against a
// value-level reference, streaming handshake, and asynchronous reset abort.
module tb_binary16_div;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        data_valid_in;
  logic        ready;
  logic [15:0] result;
  logic        data_valid_out;

  int n_checks = 0;
  int n_pass   = 0;

  binary16_div dut (
    .clk_in(clk_in), .rst_n(rst_n), .a(a), .b(b), .data_valid_in(data_valid_in),
    .ready(ready), .result(result), .data_valid_out(data_valid_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference: quotient of the significands as an integer, then normalize by its magnitude.
  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
    int ex, ey, mx, my, q, e, mant;
    bit s, xnan, ynan, xinf, yinf, xz, yz;
    s = x[15] ^ y[15];
    ex = x[14:10]; ey = y[14:10];
    xnan = (ex == 31) && (x[9:0] != 0); ynan = (ey == 31) && (y[9:0] != 0);
    xinf = (ex == 31) && (x[9:0] == 0); yinf = (ey == 31) && (y[9:0] == 0);
    xz = (ex == 0); yz = (ey == 0);
    if (xnan || ynan || (xz && yz) || (xinf && yinf)) return 16'h7E00;
    if (xz || yinf) return {s, 15'h0};
    if (yz || xinf) return {s, 5'h1F, 10'h0};
    mx = 1024 + int'(x[9:0]);
    my = 1024 + int'(y[9:0]);
    q = (mx * 2048) / my;
    if (q >= 2048) begin
      mant = (q / 2) % 1024;
      e = ex - ey + 15;
    end else begin
      mant = q % 1024;
      e = ex - ey + 14;
    end
    if (e >= 31) return {s, 5'h1F, 10'h0};
    if (e <= 0)  return {s, 15'h0};
    return {s, 5'(e), 10'(mant)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    if ($urandom_range(0, 3) == 0) v = 16'($urandom);
    else v = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
    return v;
  endfunction

  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic [15:0] expv,
                        input string name);
    int lat;
    int waited;
    bit rdy_hi;
    logic [15:0] res_cap;
    lat = 0; waited = 0; rdy_hi = 0; res_cap = 16'hxxxx;
    @(negedge clk_in);
    while (!ready && waited < 30) begin
      @(negedge clk_in);
      waited++;
    end
    if (!ready) begin
      check({name, "_ready_timeout"}, 32'(ready), 32'd1);
      return;
    end
    a = xa; b = xb; data_valid_in = 1'b1;
    @(posedge clk_in);
    #1 data_valid_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_in);
      #1;
      if (k < 13 && ready) rdy_hi = 1;
      if (data_valid_out && lat == 0) begin
        lat = k;
        res_cap = result;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'd13);
    check({name, "_result"}, 32'(res_cap), 32'(expv));
    check({name, "_busy"}, 32'(rdy_hi), 32'd0);
  endtask

  logic [15:0] ops_a[56];
  logic [15:0] ops_b[56];

  initial begin
    vecs[0]  = '{16'h3E00, 16'h4000, 16'h3A00, "1p5_div_2"};
    vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, "one_third"};
    vecs[2]  = '{16'hBC00, 16'h3C00, 16'hBC00, "neg_one"};
    vecs[3]  = '{16'h3C00, 16'h0000, 16'h7C00, "x_div_0"};
    vecs[4]  = '{16'hBC00, 16'h0000, 16'hFC00, "negx_div_0"};
    vecs[5]  = '{16'h0000, 16'h0000, 16'h7E00, "zero_div_zero"};
    vecs[6]  = '{16'h7C00, 16'h7C00, 16'h7E00, "inf_div_inf"};
    vecs[7]  = '{16'h7E01, 16'h3C00, 16'h7E00, "nan_in"};
    vecs[8]  = '{16'h3C00, 16'h7C00, 16'h0000, "x_div_inf"};
    vecs[9]  = '{16'h7BFF, 16'h0400, 16'h7C00, "overflow"};
    vecs[10] = '{16'h0400, 16'h7BFF, 16'h0000, "underflow"};
    vecs[11] = '{16'h8400, 16'h7BFF, 16'h8000, "neg_underflow"};

    rst_n = 1'b0; data_valid_in = 1'b0; a = 16'h0; b = 16'h0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_dvo", 32'(data_valid_out), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      ra = rand_op();
      rb = rand_op();
      run_op(ra, rb, model(ra, rb), $sformatf("rand%0d", i));
    end

    // Streaming: request held high, operands change every cycle; accepts land every 14 edges.
    repeat (2) @(negedge clk_in);
    a = rand_op(); b = rand_op(); data_valid_in = 1'b1;
    for (int k = 0; k < 56; k++) begin
      @(posedge clk_in);
      ops_a[k] = a; ops_b[k] = b;
      #1;
      check($sformatf("stream_dvo%0d", k), 32'(data_valid_out), 32'((k % 14) == 13));
      check($sformatf("stream_rdy%0d", k), 32'(ready), 32'((k % 14) == 13));
      if ((k % 14) == 13)
        check($sformatf("stream_res%0d", k), 32'(result), 32'(model(ops_a[k-13], ops_b[k-13])));
      if (k == 55) data_valid_in = 1'b0;
      else begin
        a = rand_op(); b = rand_op();
      end
    end
    repeat (3) @(posedge clk_in);

    // Asynchronous reset mid-division aborts the operation.
    @(negedge clk_in);
    a = 16'h4000; b = 16'h4000; data_valid_in = 1'b1;
    @(posedge clk_in);
    #1 data_valid_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_dvo", 32'(data_valid_out), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk_in);
        #1;
        if (data_valid_out) seen = 1;
      end
      check("arst_no_pulse", 32'(seen), 32'd0);
    end
    run_op(16'h4000, 16'h4000, 16'h3C00, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
